// File: rtl/lsu_ctrl_if.sv
// -----------------------------------------------------------------------------
// lsu_ctrl_if : word-oriented memory bus between the load/store unit and memory.
//
//   mem_req    LSU -> MEM  access request, held until acknowledged
//   mem_we     LSU -> MEM  1 = write, 0 = read
//   mem_addr   LSU -> MEM  word-aligned byte address
//   mem_be     LSU -> MEM  byte-lane enables
//   mem_wdata  LSU -> MEM  write data already placed in its byte lanes
//   mem_rdata  MEM -> LSU  read word, valid with mem_ack
//   mem_ack    MEM -> LSU  completes the current request
//
// master modport is the LSU side, slave modport the memory side.
// -----------------------------------------------------------------------------
interface lsu_ctrl_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl : load/store unit controller.
//
// Accepts one core request (start + access-type strobe), turns it into one or
// two word accesses on the memory bus, then returns the aligned and extended
// load result together with a one-cycle done pulse.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   start                       one-cycle request pulse from the core
//   lb lh lw lbu lhu sb sh sw   access-type strobes, sampled with start
//   addr, wdata                 byte address, right-aligned store data
//   stall                       freeze PC/pipeline while the access runs
//   done                        one-cycle completion pulse
//   rdata                       load result, held until the next done
//   misalign_err                pulses with done on a rejected misaligned access
//   mem                         memory bus (lsu_ctrl_if.master)
//
// Build option
//   LSU_MISALIGN_SPLIT_EN  defined   : accesses crossing a word boundary are
//                                      split into two word accesses.
//                          undefined : misaligned half/word accesses skip memory
//                                      and finish with misalign_err.
// -----------------------------------------------------------------------------
module lsu_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        lb,
   input  logic        lh,
   input  logic        lw,
   input  logic        lbu,
   input  logic        lhu,
   input  logic        sb,
   input  logic        sh,
   input  logic        sw,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata,
   output logic        misalign_err,
   lsu_ctrl_if.master  mem
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACC1 = 2'd1, ACC2 = 2'd2, RESP = 2'd3} state_t;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  size_q, size_d;
   logic        sext_q, sext_d;
   logic        we_q, we_d;
   logic        err_q, err_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] rdata_q, rdata_d;

   logic        req_valid_s;
   logic [1:0]  size_s;
   logic        sext_s;
   logic        we_s;
   logic        misalign_s;
   logic        split_s;
   logic [3:0]  base_be_s;
   logic [7:0]  be8_s;
   logic [63:0] wd64_s;

   // Shift the (possibly two-word) read data down to the access offset and extend.
   function automatic logic [31:0] load_extract(input logic [63:0] words,
                                                input logic [1:0]  off,
                                                input logic [1:0]  size,
                                                input logic        sext);
      logic [31:0] shv;
      shv = 32'(words >> {off, 3'b000});
      case (size)
         SZ_B:    load_extract = sext ? {{24{shv[7]}}, shv[7:0]}   : {24'h00_0000, shv[7:0]};
         SZ_H:    load_extract = sext ? {{16{shv[15]}}, shv[15:0]} : {16'h0000, shv[15:0]};
         SZ_W:    load_extract = shv;
         default: load_extract = 32'h0000_0000;
      endcase
   endfunction

   // Strobe decode with fixed priority lw > lh > lhu > lb > lbu > sw > sh > sb.
   always_comb begin
      req_valid_s = 1'b1;
      size_s      = SZ_W;
      sext_s      = 1'b0;
      we_s        = 1'b0;
      if (lw) begin
         size_s = SZ_W;
      end else if (lh) begin
         size_s = SZ_H;
         sext_s = 1'b1;
      end else if (lhu) begin
         size_s = SZ_H;
      end else if (lb) begin
         size_s = SZ_B;
         sext_s = 1'b1;
      end else if (lbu) begin
         size_s = SZ_B;
      end else if (sw) begin
         size_s = SZ_W;
         we_s   = 1'b1;
      end else if (sh) begin
         size_s = SZ_H;
         we_s   = 1'b1;
      end else if (sb) begin
         size_s = SZ_B;
         we_s   = 1'b1;
      end else begin
         req_valid_s = 1'b0;
      end
   end

   // Lane placement of the latched access across two consecutive words:
   // the upper nibble / upper word is what spills into the second access.
   always_comb begin
      case (size_q)
         SZ_B:    base_be_s = 4'b0001;
         SZ_H:    base_be_s = 4'b0011;
         SZ_W:    base_be_s = 4'b1111;
         default: base_be_s = 4'b0000;
      endcase
      be8_s  = {4'b0000, base_be_s} << addr_q[1:0];
      wd64_s = {32'h0000_0000, wdata_q} << {addr_q[1:0], 3'b000};
   end

`ifdef LSU_MISALIGN_SPLIT_EN
   assign misalign_s = 1'b0;
   assign split_s    = |be8_s[7:4];
`else
   // Halfword at offset 2 stays inside the word and is legal.
   assign misalign_s = ((size_s == SZ_H) && addr[0]) ||
                       ((size_s == SZ_W) && (addr[1:0] != 2'b00));
   assign split_s    = 1'b0;
`endif

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      size_d  = size_q;
      sext_d  = sext_q;
      we_d    = we_q;
      err_d   = err_q;
      lo_d    = lo_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (start && req_valid_s) begin
               addr_d  = addr;
               wdata_d = wdata;
               size_d  = size_s;
               sext_d  = sext_s;
               we_d    = we_s;
               if (misalign_s) begin
                  err_d   = 1'b1;
                  rdata_d = 32'h0000_0000;
                  state_d = RESP;
               end else begin
                  err_d   = 1'b0;
                  state_d = ACC1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         ACC1: begin
            if (mem.mem_ack) begin
               if (split_s) begin
                  lo_d    = mem.mem_rdata;
                  state_d = ACC2;
               end else begin
                  rdata_d = we_q ? 32'h0000_0000
                                 : load_extract({32'h0000_0000, mem.mem_rdata}, addr_q[1:0], size_q, sext_q);
                  state_d = RESP;
               end
            end else begin
               state_d = ACC1;
            end
         end
         ACC2: begin
            if (mem.mem_ack) begin
               rdata_d = we_q ? 32'h0000_0000
                              : load_extract({mem.mem_rdata, lo_q}, addr_q[1:0], size_q, sext_q);
               state_d = RESP;
            end else begin
               state_d = ACC2;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= 32'h0000_0000;
         wdata_q <= 32'h0000_0000;
         size_q  <= SZ_B;
         sext_q  <= 1'b0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         lo_q    <= 32'h0000_0000;
         rdata_q <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         sext_q  <= sext_d;
         we_q    <= we_d;
         err_q   <= err_d;
         lo_q    <= lo_d;
         rdata_q <= rdata_d;
      end
   end

   // Memory bus drive: decoded only from registers, so it is stable while waiting for ack.
   always_comb begin
      mem.mem_req   = 1'b0;
      mem.mem_we    = 1'b0;
      mem.mem_addr  = 32'h0000_0000;
      mem.mem_be    = 4'b0000;
      mem.mem_wdata = 32'h0000_0000;
      if (state_q == ACC1) begin
         mem.mem_req   = 1'b1;
         mem.mem_we    = we_q;
         mem.mem_addr  = {addr_q[31:2], 2'b00};
         mem.mem_be    = be8_s[3:0];
         mem.mem_wdata = wd64_s[31:0];
      end else if (state_q == ACC2) begin
         mem.mem_req   = 1'b1;
         mem.mem_we    = we_q;
         mem.mem_addr  = {addr_q[31:2], 2'b00} + 32'd4;
         mem.mem_be    = be8_s[7:4];
         mem.mem_wdata = wd64_s[63:32];
      end else begin
         mem.mem_req   = 1'b0;
      end
   end

   assign done         = (state_q == RESP);
   assign misalign_err = (state_q == RESP) && err_q;
   assign rdata        = rdata_q;
   // Stall must rise in the same cycle the request is accepted, hence the start term;
   // rst_n gating keeps it low while reset is asserted.
   assign stall        = rst_n && (((state_q == IDLE) && start && req_valid_s) ||
                                   (state_q == ACC1) || (state_q == ACC2));

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: start  input  1  core request, one-cycle pulse.
REQ-004 SHALL have ports: lb, lh, lw, lbu, lhu, sb, sh, sw  input  1 each  access-type strobes from control_unit, sampled with start.
REQ-005 SHALL have ports: addr  input  32  byte address; wdata  input  32  store data, right-aligned.
REQ-006 SHALL have ports: stall  output  1  freeze PC/pipeline; done  output  1  completion pulse; rdata  output  32  load result, extended; misalign_err  output  1  error pulse with done.
REQ-007 SHALL have ports: mem_req  output  1; mem_we  output  1; mem_addr  output  32  word-aligned; mem_be  output  4; mem_wdata  output  32; mem_rdata  input  32; mem_ack  input  1.

Function
REQ-008 SHALL implement FSM states IDLE, ACC1, ACC2, RESP.
REQ-009 SHALL, in IDLE with start=1 and at least one strobe, latch addr/wdata/type and go to ACC1; start with no strobe SHALL be ignored.
REQ-010 SHALL resolve multiple strobes by priority lw>lh>lhu>lb>lbu>sw>sh>sb.
REQ-011 SHALL ignore start outside IDLE.
REQ-012 SHALL hold mem_req=1 and mem_addr/mem_be/mem_we/mem_wdata stable in ACC1/ACC2 until a cycle with mem_ack=1; mem_req=0 in IDLE and RESP.
REQ-013 SHALL set mem_addr = {addr[31:2],2'b00} in ACC1, mem_addr+4 (modulo 2^32) in ACC2.
REQ-014 SHALL set mem_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; bits shifted beyond bit 3 go to ACC2 as the low bits.
REQ-015 SHALL shift store data left by 8*addr[1:0] for mem_wdata, spilled bytes placed in ACC2 low lanes.
REQ-016 SHALL, on ack in ACC1, go to ACC2 if access is split, else RESP; on ack in ACC2, go to RESP.
REQ-017 SHALL capture mem_rdata on each load ack; rdata = selected bytes right-aligned, sign-extended for lb/lh, zero-extended for lbu/lhu/lw; rdata=0 after stores.
REQ-018 SHALL assert done=1 for exactly one cycle in RESP, then return to IDLE; rdata SHALL hold until next done.
REQ-019 SHALL drive stall = start_accepted_in_IDLE | (state==ACC1) | (state==ACC2); stall=0 in RESP.
REQ-020 Latency: aligned access with mem_ack=1 held high SHALL give done 2 cycles after start; split access 3 cycles.
REQ-021 mem_ack in IDLE or RESP SHALL be ignored.

Reset
REQ-022 rst_n=0 SHALL immediately force state IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, done=0, stall=0, misalign_err=0, rdata=0, including mid-access; an outstanding ack after reset SHALL be ignored.

Configuration
REQ-023 With LSU_MISALIGN_SPLIT_EN defined, accesses crossing a word boundary SHALL be split into ACC1+ACC2 per REQ-013..017.
REQ-024 Without LSU_MISALIGN_SPLIT_EN, a misaligned half (addr[0]=1) or word (addr[1:0]!=0) SHALL skip memory (no mem_req), go IDLE->RESP, pulse done with misalign_err=1, rdata=0; halfword at addr[1:0]=2 remains legal and unsplit.

Verification
REQ-025 lw addr=0x100, mem_rdata=0xDEADBEEF, ack immediate -> mem_be=1111, mem_addr=0x100, done 2 cycles after start, rdata=0xDEADBEEF.
REQ-026 lb addr=0x103, mem_rdata=0x80FFFFFF -> mem_be=1000, rdata=0xFFFFFF80; lbu same -> rdata=0x00000080.
REQ-027 sh addr=0x202, wdata=0x0000ABCD, ack delayed 3 cycles -> mem_we=1, mem_be=1100, mem_wdata=0xABCD0000 stable 4 cycles, stall high throughout, done once.
REQ-028 SPLIT_EN: lw addr=0xFFFFFFFE, rdata 0x1122xxxx then 0xxxxx3344 -> ACC1 addr 0xFFFFFFFC be 1100, ACC2 addr 0x00000000 be 0011, rdata=0x33441122; without SPLIT_EN -> no mem_req, misalign_err=1 with done.
REQ-029 rst_n pulled low in ACC1 while mem_ack=0 -> mem_req=0 same cycle; after release, late ack -> no done; next start proceeds normally.
